// File: rtl/melody_sequencer_if.sv
// Key input and melody outputs shared between the sequencer and its consumer.
interface melody_sequencer_if #(
  parameter int unsigned W = 8
);
  logic         key1;
  logic         key_press;
  logic         busy;
  logic         tone_en;
  logic [W-1:0] half_period;
  logic [2:0]   step_idx;

  modport master (
    output key1,
    input  key_press, busy, tone_en, half_period, step_idx
  );

  modport slave (
    input  key1,
    output key_press, busy, tone_en, half_period, step_idx
  );
endinterface

// File: rtl/melody_sequencer.sv
// Debounced key starts/aborts playback of a fixed 8-step melody ROM on a tempo grid.
module melody_sequencer #(
  parameter int unsigned CLK_REF  = 5000,
  parameter int unsigned NOTE_MIN = 21,
  parameter int unsigned TEMP     = 8,
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned GAP_CYC  = 50,
  parameter int unsigned LOOP     = 0
) (
  input logic               clk,
  input logic               rst,
  melody_sequencer_if.slave bus
);

  localparam int unsigned WIDTH_NOTE_MIN = $clog2(CLK_REF / NOTE_MIN);
  localparam int unsigned RANG_TEMP      = CLK_REF * 4 / TEMP;
  localparam int unsigned DUR_W          = $clog2(2 * RANG_TEMP + 1);
  localparam int unsigned DB_W           = $clog2(DEBOUNCE + 1);

  // Half-periods of the three pitches used by the ROM, truncated.
  localparam int unsigned HP_E = CLK_REF / (2 * 330);
  localparam int unsigned HP_D = CLK_REF / (2 * 294);
  localparam int unsigned HP_C = CLK_REF / (2 * 262);

  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  if (((HP_E >> WIDTH_NOTE_MIN) != 0) || ((HP_D >> WIDTH_NOTE_MIN) != 0) ||
      ((HP_C >> WIDTH_NOTE_MIN) != 0)) begin : g_hp_range
    $error("melody_sequencer: ROM half-period does not fit WIDTH_NOTE_MIN");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // ROM pitch column, stored as half-periods (0 = rest).
  function automatic logic [WIDTH_NOTE_MIN-1:0] hp_of(input logic [2:0] s);
    case (s)
      3'd0, 3'd4, 3'd5, 3'd6: hp_of = WIDTH_NOTE_MIN'(HP_E);
      3'd1, 3'd3:             hp_of = WIDTH_NOTE_MIN'(HP_D);
      3'd2:                   hp_of = WIDTH_NOTE_MIN'(HP_C);
      default:                hp_of = '0;
    endcase
  endfunction

  // ROM length column, as the last duration-counter value of the step.
  function automatic logic [DUR_W-1:0] play_last(input logic [2:0] s);
    if (s == 3'd6) play_last = DUR_W'(2 * RANG_TEMP - 1);
    else           play_last = DUR_W'(RANG_TEMP - 1);
  endfunction

  logic                      key_s1, key_s2, key_db, key_db_d;
  logic [DB_W-1:0]           db_cnt;
  logic                      key_press_q;

  state_t                    state;
  logic [DUR_W-1:0]          dur;
  logic                      busy_q, tone_q;
  logic [WIDTH_NOTE_MIN-1:0] hp_q;
  logic [2:0]                step_q;

  logic [2:0]                next_step;
  logic [WIDTH_NOTE_MIN-1:0] next_hp;
  logic                      last_step;

  // Step 7 wraps to 0, which is exactly the looping successor.
  assign next_step = step_q + 3'd1;
  assign next_hp   = hp_of(next_step);
  assign last_step = (step_q == 3'd7);

  // Synchronise the raw key, debounce it and pulse on the debounced falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1      <= 1'b1;
      key_s2      <= 1'b1;
      key_db      <= 1'b1;
      key_db_d    <= 1'b1;
      db_cnt      <= '0;
      key_press_q <= 1'b0;
    end else begin
      key_s1      <= bus.key1;
      key_s2      <= key_s1;
      key_db_d    <= key_db;
      key_press_q <= key_db_d & ~key_db;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Playback FSM with registered outputs; a press while busy aborts to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      dur    <= '0;
      busy_q <= 1'b0;
      tone_q <= 1'b0;
      hp_q   <= '0;
      step_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_press_q) begin
            state  <= S_PLAY;
            dur    <= '0;
            busy_q <= 1'b1;
            step_q <= 3'd0;
            hp_q   <= hp_of(3'd0);
            tone_q <= (hp_of(3'd0) != '0);
          end
        end
        S_PLAY: begin
          if (key_press_q) begin
            state  <= S_IDLE;
            dur    <= '0;
            busy_q <= 1'b0;
            tone_q <= 1'b0;
            hp_q   <= '0;
            step_q <= '0;
          end else if (dur == play_last(step_q)) begin
            state  <= S_GAP;
            dur    <= '0;
            tone_q <= 1'b0;
          end else begin
            dur <= dur + DUR_W'(1);
          end
        end
        S_GAP: begin
          if (key_press_q || (dur == GAP_LAST && last_step && LOOP == 0)) begin
            state  <= S_IDLE;
            dur    <= '0;
            busy_q <= 1'b0;
            tone_q <= 1'b0;
            hp_q   <= '0;
            step_q <= '0;
          end else if (dur == GAP_LAST) begin
            state  <= S_PLAY;
            dur    <= '0;
            step_q <= next_step;
            hp_q   <= next_hp;
            tone_q <= (next_hp != '0);
          end else begin
            dur <= dur + DUR_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          dur    <= '0;
          busy_q <= 1'b0;
          tone_q <= 1'b0;
          hp_q   <= '0;
          step_q <= '0;
        end
      endcase
    end
  end

  assign bus.key_press   = key_press_q;
  assign bus.busy        = busy_q;
  assign bus.tone_en     = tone_q;
  assign bus.half_period = hp_q;
  assign bus.step_idx    = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench: one-shot and looping sequencers driven by the same key, checked against a timeline model.
module tb_melody_sequencer;

  localparam int RANG   = 2500;
  localparam int GAP    = 50;
  localparam int TOTAL  = 9 * RANG + 8 * GAP;

  logic clk = 1'b0;
  logic rst;
  logic key1;
  logic chk_en = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_press = 0;

  int freq [8] = '{330, 294, 262, 294, 330, 330, 330, 0};
  int lenv [8] = '{1, 1, 1, 1, 1, 1, 2, 1};

  melody_sequencer_if #(.W(8)) bus0 ();
  melody_sequencer_if #(.W(8)) bus1 ();

  assign bus0.key1 = key1;
  assign bus1.key1 = key1;

  melody_sequencer #(.LOOP(0)) u_once (.clk(clk), .rst(rst), .bus(bus0));
  melody_sequencer #(.LOOP(1)) u_loop (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs at t cycles after melody start, walking the step timeline.
  function automatic void expect_at(input bit act, input int t, output logic busy,
                                    output logic tone, output int hp, output int step);
    int rem;
    int p;
    int h;
    busy = 1'b0; tone = 1'b0; hp = 0; step = 0;
    if (!act) return;
    busy = 1'b1;
    rem  = t;
    for (int s = 0; s < 8; s++) begin
      p = lenv[s] * RANG;
      h = (freq[s] == 0) ? 0 : 5000 / (2 * freq[s]);
      if (rem < p) begin
        step = s; hp = h; tone = (h != 0);
        return;
      end
      rem -= p;
      if (rem < GAP) begin
        step = s; hp = h; tone = 1'b0;
        return;
      end
      rem -= GAP;
    end
  endfunction

  // Model: key debounced as "last 16 synced samples all differ", melody as elapsed time.
  logic        m_s1, m_s2, m_db, m_dbd, m_press;
  logic [15:0] hist;
  int          hist_n;
  bit          m_act [2];
  int          m_t   [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= 1'b1; m_s2 <= 1'b1; m_db <= 1'b1; m_dbd <= 1'b1; m_press <= 1'b0;
      hist <= '1; hist_n <= 0;
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_t[i]   <= 0;
      end
    end else begin
      m_s1    <= key1;
      m_s2    <= m_s1;
      hist    <= {hist[14:0], m_s2};
      hist_n  <= (hist_n < 16) ? hist_n + 1 : 16;
      m_press <= m_dbd & ~m_db;
      m_dbd   <= m_db;
      if (hist_n >= 15 && {hist[14:0], m_s2} == {16{~m_db}}) m_db <= ~m_db;
      for (int i = 0; i < 2; i++) begin
        if (m_press) begin
          m_act[i] <= !m_act[i];
          m_t[i]   <= 0;
        end else if (m_act[i]) begin
          if (m_t[i] + 1 == TOTAL) begin
            m_t[i] <= 0;
            if (i == 0) m_act[i] <= 1'b0;
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end
      end
    end
  end

  // Compare both DUTs against the model every cycle, away from the active edge.
  logic        e_busy, e_tone;
  int          e_hp, e_step;
  logic [13:0] a_vec, e_vec;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        expect_at(m_act[i], m_t[i], e_busy, e_tone, e_hp, e_step);
        e_vec = {m_press, e_busy, e_tone, 8'(e_hp), 3'(e_step)};
        if (i == 0)
          a_vec = {bus0.key_press, bus0.busy, bus0.tone_en, bus0.half_period, bus0.step_idx};
        else
          a_vec = {bus1.key_press, bus1.busy, bus1.tone_en, bus1.half_period, bus1.step_idx};
        check(i == 0 ? "model_once" : "model_loop", 32'(a_vec), 32'(e_vec));
      end
      if (bus0.key_press === 1'b1) n_press++;
    end
  end

  task automatic wait_press(input string name);
    bit found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus0.key_press === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_step(input string name, input int s, input int budget);
    bit found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus0.busy === 1'b1 && bus0.step_idx == 3'(s)) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    int cyc;
    bit found;
    int busy_cyc, tone_cyc, gap0_cyc;
    int hp_seq[$];
    logic prev_busy;
    logic [2:0] prev_step;
    int exp_hp [8] = '{7, 8, 9, 8, 7, 7, 7, 0};

    key1 = 1'b1;
    rst  = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Idle with key released.
    repeat (100) @(negedge clk);
    check("t1_no_press", 32'(n_press), 32'd0);
    check("t1_outputs", 32'({bus0.busy, bus0.tone_en, bus0.half_period, bus0.step_idx}), 32'd0);

    // Bounce shorter than the debounce window.
    for (int k = 0; k < 12; k++) begin
      key1 = (k % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) @(negedge clk);
    end
    key1 = 1'b1;
    repeat (40) @(negedge clk);
    check("t2_no_press", 32'(n_press), 32'd0);
    check("t2_busy", 32'(bus0.busy), 32'd0);

    // Steady press: pulse latency and first-step outputs.
    key1  = 1'b0;
    cyc   = 0;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus0.key_press === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_press_found", 32'(found), 32'd1);
    check("t3_press_latency", 32'(cyc), 32'd19);
    @(posedge clk); #1;
    check("t3_busy", 32'(bus0.busy), 32'd1);
    check("t3_tone", 32'(bus0.tone_en), 32'd1);
    check("t3_hp", 32'(bus0.half_period), 32'd7);
    check("t3_step", 32'(bus0.step_idx), 32'd0);
    check("t3_press_width", 32'(bus0.key_press), 32'd0);

    // Full one-shot run, key held then released partway.
    busy_cyc = 0; tone_cyc = 0; gap0_cyc = 0;
    prev_busy = 1'b0; prev_step = 3'd0;
    found = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (c == 200) begin
        check("t3_held_one_press", 32'(n_press), 32'd1);
        key1 = 1'b1;
      end
      if (!bus0.busy) begin
        found = 1'b1;
        break;
      end
      busy_cyc++;
      if (bus0.tone_en) tone_cyc++;
      if (!bus0.tone_en && bus0.step_idx == 3'd0) gap0_cyc++;
      if (!prev_busy || bus0.step_idx != prev_step) hp_seq.push_back(int'(bus0.half_period));
      prev_busy = bus0.busy;
      prev_step = bus0.step_idx;
    end
    check("t4_finished", 32'(found), 32'd1);
    check("t4_busy_cycles", 32'(busy_cyc), 32'(TOTAL));
    check("t4_busy_cycles_lit", 32'(busy_cyc), 32'd22900);
    check("t4_tone_cycles", 32'(tone_cyc), 32'd20000);
    check("t4_gap0_cycles", 32'(gap0_cyc), 32'd50);
    check("t4_nsteps", 32'(hp_seq.size()), 32'd8);
    for (int s = 0; s < 8 && s < hp_seq.size(); s++)
      check($sformatf("t4_hp_step%0d", s), 32'(hp_seq[s]), 32'(exp_hp[s]));
    check("t6_loop_busy", 32'(bus1.busy), 32'd1);
    check("t6_loop_step", 32'(bus1.step_idx), 32'd0);
    check("t6_loop_hp", 32'(bus1.half_period), 32'd7);

    // Abort during step 2, then restart.
    key1 = 1'b0;
    wait_press("t5_press1");
    @(negedge clk) key1 = 1'b1;
    wait_step("t5_reach_step2", 2, 6000);
    key1 = 1'b0;
    wait_press("t5_press2");
    @(posedge clk); #1;
    check("t5_abort_busy", 32'(bus0.busy), 32'd0);
    check("t5_abort_tone", 32'(bus0.tone_en), 32'd0);
    check("t5_abort_step", 32'(bus0.step_idx), 32'd0);
    key1 = 1'b1;
    repeat (40) @(negedge clk);
    key1 = 1'b0;
    wait_press("t5_press3");
    @(posedge clk); #1;
    check("t5_restart_busy", 32'(bus0.busy), 32'd1);
    check("t5_restart_step", 32'(bus0.step_idx), 32'd0);
    check("t5_restart_hp", 32'(bus0.half_period), 32'd7);
    key1 = 1'b1;

    // Asynchronous reset during step 4.
    wait_step("t6_reach_step4", 4, 12000);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_outputs",
          32'({bus0.key_press, bus0.busy, bus0.tone_en, bus0.half_period, bus0.step_idx}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_idle_after_rst", 32'(bus0.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
